// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive framer.
//   state_e      framer FSM states
//   DIBIT_*      preamble / SFD-tail dibit codes
//   DIV10        10 Mb/s sample divider
//   CRC_*        CRC-32 polynomial and good-frame residue, plus a 1-bit step helper
package rmii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DISC = 2'd3
  } state_e;

  localparam logic [1:0]  DIBIT_PRE   = 2'b01;
  localparam logic [1:0]  DIBIT_SFD   = 2'b11;
  localparam int unsigned DIV10       = 10;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // One serial CRC-32 step, bits taken in wire order.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/rmii_crc32_dibit.sv
// CRC-32 engine advancing two bits (one RMII dibit, bit0 first) per enabled cycle.
// Ports: rmii_refclk/rst_l clock and async active-low reset; init preloads all-ones
// (wins over en); en consumes din; crc is the running register (no final inversion).
module rmii_crc32_dibit
  import rmii_pkg::*;
(
  input  logic        rmii_refclk,
  input  logic        rst_l,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = '1;
    end else if (en) begin
      crc_d = crc_step(crc_step(crc_q, din[0]), din[1]);
    end
  end

  always_ff @(posedge rmii_refclk or negedge rst_l) begin
    if (!rst_l) crc_q <= '1;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: samples crs_dv/rxd/rx_er, strips preamble/SFD, packs dibits
// LSB-first into OUT_W-bit words and queues {data,last,err} for a valid/ready sink.
// Ports: rmii_refclk, rst_l (async active-low), speed_10, rmii_crs_dv, rmii_rxd,
//   rmii_rx_er in; m_data/m_valid/m_last/m_err out with m_ready in; busy;
//   frm_cnt (good frames delivered), drop_cnt (errored or discarded frames).
// Build option: RMII_RX_FCS_CHECK_EN adds a CRC-32 residue check into m_err.
module rmii_rx_framer
  import rmii_pkg::*;
#(
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             rmii_refclk,
  input  logic             rst_l,
  input  logic             speed_10,
  input  logic             rmii_crs_dv,
  input  logic [1:0]       rmii_rxd,
  input  logic             rmii_rx_er,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             m_err,
  output logic             busy,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned DIBITS = OUT_W / 2;
  localparam int unsigned DC_W   = (DIBITS > 1) ? $clog2(DIBITS) : 1;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned EW     = OUT_W + 2;

  state_e state_q, state_d;

  logic [3:0]       div_q, div_d, div_cur_c;
  logic             crs_prev_q, crs_prev_d;
  logic             pv_q, pv_d, pcrs_q, pcrs_d;
  logic [1:0]       pd_q, pd_d;
  logic [OUT_W-1:0] sh_q, sh_d, word_new_c;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic             stg_v_q, stg_v_d, ferr_q, ferr_d, eop_v_q, eop_v_d;
  logic [OUT_W-1:0] stg_data_q, stg_data_d, eop_data_q, eop_data_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    head_c, push_entry_c;

  logic strobe_c, sfd_c, eof_c, commit_c, crc_bad_c, err_fin_c;
  logic full_c, pop_c, space_c, push_c, wr_en_c, drop_fsm_c, pop_last_c;

  // Sample strobe: every clock at 100M; at 10M phase 0 of a divider re-aligned on carrier rise.
  always_comb begin
    crs_prev_d = rmii_crs_dv;
    div_cur_c  = (rmii_crs_dv && !crs_prev_q) ? 4'd0 : div_q;
    strobe_c   = !speed_10 || (div_cur_c == 4'd0);
    div_d      = (div_cur_c == 4'(DIV10 - 1)) ? 4'd0 : div_cur_c + 4'd1;
  end

  // A dibit sampled with crs_dv=0 is held one sample: it becomes data only if carrier returns.
  assign sfd_c    = rmii_crs_dv && (rmii_rxd == DIBIT_SFD);
  assign eof_c    = strobe_c && (state_q == ST_DATA) && !rmii_crs_dv && pv_q && !pcrs_q;
  assign commit_c = strobe_c && (state_q == ST_DATA) && !eof_c && pv_q;

`ifdef RMII_RX_FCS_CHECK_EN
  logic        crc_init_c;
  logic [31:0] crc_c;

  assign crc_init_c = strobe_c && (state_q == ST_PRE) && sfd_c;

  rmii_crc32_dibit u_crc (
    .rmii_refclk (rmii_refclk),
    .rst_l       (rst_l),
    .init        (crc_init_c),
    .en          (commit_c),
    .din         (pd_q),
    .crc         (crc_c)
  );

  assign crc_bad_c = (crc_c != CRC_RESIDUE);
`else
  assign crc_bad_c = 1'b0;
`endif

  // FIFO status; a same-cycle pop frees the slot for a push.
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign m_valid = (wr_ptr_q != rd_ptr_q);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_c   = m_valid && m_ready;
  assign space_c = !full_c || pop_c;
  assign wr_en_c = push_c && space_c;

  assign m_data = m_valid ? head_c[EW-1:2] : '0;
  assign m_last = m_valid && head_c[1];
  assign m_err  = m_valid && head_c[0];
  assign busy   = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge rmii_refclk or negedge rst_l) begin
    if (!rst_l) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; only moves on a sample strobe.
  always_comb begin
    state_d = state_q;
    if (strobe_c) begin
      unique case (state_q)
        ST_IDLE: if (rmii_crs_dv) state_d = eop_v_q ? ST_DISC : ST_PRE;
        ST_PRE: begin
          if (!rmii_crs_dv)                                      state_d = ST_IDLE;
          else if (sfd_c)                                        state_d = ST_DATA;
          else if ((rmii_rxd != DIBIT_PRE) && (rmii_rxd != 2'b00)) state_d = ST_DISC;
        end
        ST_DATA: if (eof_c) state_d = ST_IDLE;
        ST_DISC: if (!rmii_crs_dv && !pcrs_q) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: dibit packing, one-word staging (to know m_last), EOP hold, FIFO push requests.
  always_comb begin
    pv_d         = pv_q;
    pcrs_d       = pcrs_q;
    pd_d         = pd_q;
    sh_d         = sh_q;
    dcnt_d       = dcnt_q;
    stg_v_d      = stg_v_q;
    stg_data_d   = stg_data_q;
    ferr_d       = ferr_q;
    eop_v_d      = eop_v_q;
    eop_data_d   = eop_data_q;
    push_c       = 1'b0;
    push_entry_c = '0;
    drop_fsm_c   = 1'b0;
    word_new_c   = (sh_q >> 2) | (OUT_W'(pd_q) << (OUT_W - 2));
    err_fin_c    = ferr_q || (dcnt_q != '0) || crc_bad_c;

    // Held final word drains as soon as a slot exists; no frame is in DATA meanwhile.
    if (eop_v_q && space_c) begin
      push_c       = 1'b1;
      push_entry_c = {eop_data_q, 2'b11};
      eop_v_d      = 1'b0;
    end

    if (strobe_c) begin
      unique case (state_q)
        ST_IDLE: pcrs_d = 1'b1;
        ST_PRE: begin
          pcrs_d = 1'b1;
          if (sfd_c) begin
            pv_d    = 1'b0;
            dcnt_d  = '0;
            stg_v_d = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        ST_DATA: begin
          if (eof_c) begin
            pv_d    = 1'b0;
            stg_v_d = 1'b0;
            if (stg_v_q) begin
              push_c       = 1'b1;
              push_entry_c = {stg_data_q, 1'b1, err_fin_c};
              if (!space_c) begin
                eop_v_d    = 1'b1;
                eop_data_d = stg_data_q;
              end
            end else begin
              drop_fsm_c = 1'b1;
            end
          end else begin
            if (rmii_rx_er) ferr_d = 1'b1;
            if (commit_c) begin
              sh_d = word_new_c;
              if (dcnt_q == DC_W'(DIBITS - 1)) begin
                dcnt_d     = '0;
                stg_v_d    = 1'b1;
                stg_data_d = word_new_c;
                if (stg_v_q) begin
                  push_c       = 1'b1;
                  push_entry_c = {stg_data_q, 2'b00};
                  if (!space_c) ferr_d = 1'b1;
                end
              end else begin
                dcnt_d = dcnt_q + DC_W'(1);
              end
            end
            pv_d   = 1'b1;
            pd_d   = rmii_rxd;
            pcrs_d = rmii_crs_dv;
          end
        end
        ST_DISC: begin
          pcrs_d = rmii_crs_dv;
          if (!rmii_crs_dv && !pcrs_q) drop_fsm_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pointers and frame statistics.
  always_comb begin
    pop_last_c = pop_c && head_c[1];
    wr_ptr_d   = wr_ptr_q + PW'(wr_en_c);
    rd_ptr_d   = rd_ptr_q + PW'(pop_c);
    frm_cnt_d  = frm_cnt_q + CNT_W'(pop_last_c && !head_c[0]);
    drop_cnt_d = drop_cnt_q + CNT_W'(pop_last_c && head_c[0]) + CNT_W'(drop_fsm_c);
  end

  always_ff @(posedge rmii_refclk or negedge rst_l) begin
    if (!rst_l) begin
      div_q      <= '0;
      crs_prev_q <= 1'b0;
      pv_q       <= 1'b0;
      pcrs_q     <= 1'b0;
      pd_q       <= '0;
      sh_q       <= '0;
      dcnt_q     <= '0;
      stg_v_q    <= 1'b0;
      stg_data_q <= '0;
      ferr_q     <= 1'b0;
      eop_v_q    <= 1'b0;
      eop_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      frm_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      div_q      <= div_d;
      crs_prev_q <= crs_prev_d;
      pv_q       <= pv_d;
      pcrs_q     <= pcrs_d;
      pd_q       <= pd_d;
      sh_q       <= sh_d;
      dcnt_q     <= dcnt_d;
      stg_v_q    <= stg_v_d;
      stg_data_q <= stg_data_d;
      ferr_q     <= ferr_d;
      eop_v_q    <= eop_v_d;
      eop_data_q <= eop_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      frm_cnt_q  <= frm_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge rmii_refclk) begin
    if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_c;
  end

  assign frm_cnt  = frm_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule
